// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared states and opcode constants for the instruction sequencer
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_PAUSE = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_e;

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_PRINT = 4'd15;

    // Opcode occupies the top OPC_W bits of the instruction word.
    localparam int OPC_W = 4;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - load bus and core handshake bundle for the sequencer
interface instr_sequencer_if #(
    parameter int AW = 4,
    parameter int IW = 16
);

    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [IW-1:0] LoadData;
    logic          Start;
    logic          StepMode;
    logic          Step;
    logic          Done;
    logic [IW-1:0] Instr;
    logic          Run;
    logic [AW-1:0] Pc;
    logic          Busy;
    logic          Halted;
    logic          Fault;

    modport master (
        input  LoadEn, LoadAddr, LoadData, Start, StepMode, Step, Done,
        output Instr, Run, Pc, Busy, Halted, Fault
    );

    modport slave (
        output LoadEn, LoadAddr, LoadData, Start, StepMode, Step, Done,
        input  Instr, Run, Pc, Busy, Halted, Fault
    );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// rtl/instr_sequencer_prog_mem.sv - program store, synchronous write, asynchronous read, cleared on reset
module instr_sequencer_prog_mem #(
    parameter int AW = 4,
    parameter int IW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - steps a program counter through program memory, issuing one instruction per core Done
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int AW      = 4,
    parameter int IW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    instr_sequencer_if.master  bus
);

    localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [AW-1:0] PC_LAST   = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          done_prev_q, done_prev_d;
    logic          step_prev_q, step_prev_d;

    logic          mem_we;
    logic [IW-1:0] mem_rdata;
    logic          done_edge;
    logic          step_edge;
    logic [7:0]    cnt_inc;

    instr_sequencer_prog_mem #(
        .AW (AW),
        .IW (IW)
    ) u_mem (
        .Clock (Clock),
        .Reset (Reset),
        .we    (mem_we),
        .waddr (bus.LoadAddr),
        .wdata (bus.LoadData),
        .raddr (pc_q),
        .rdata (mem_rdata)
    );

    // Loading is only allowed while nothing is executing.
    assign mem_we = bus.LoadEn &&
                    (state_q == S_IDLE || state_q == S_HALT || state_q == S_FAULT);

    assign done_edge = bus.Done && !done_prev_q;
    assign step_edge = bus.Step && !step_prev_q;
    assign cnt_inc   = cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        done_prev_d = bus.Done;
        step_prev_d = bus.Step;

        unique case (state_q)
            S_IDLE, S_HALT, S_FAULT: begin
                if (bus.Start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = mem_rdata;
                // Opcode 0 never completes in the core, so it ends the program without a Run.
                if (mem_rdata[IW-1 -: OPC_W] == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_edge) begin
                    if (pc_q == PC_LAST) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = bus.StepMode ? S_PAUSE : S_FETCH;
                    end
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_PAUSE: begin
                if (step_edge || !bus.StepMode) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            cnt_q       <= '0;
            done_prev_q <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            done_prev_q <= done_prev_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign bus.Instr  = instr_q;
    assign bus.Run    = (state_q == S_ISSUE);
    assign bus.Pc     = pc_q;
    assign bus.Busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                        (state_q == S_WAIT)  || (state_q == S_PAUSE);
    assign bus.Halted = (state_q == S_HALT);
    assign bus.Fault  = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    instr_sequencer_if #(.AW(4), .IW(16)) bus ();

    instr_sequencer #(.AW(4), .IW(16), .TIMEOUT(15)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_run  = 0;
    int n_fail = 0;
    int run_total = 0;
    int snap;
    int n;

    always @(posedge Clock) begin
        if (bus.Run === 1'b1) run_total++;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        bus.LoadEn   = 1'b1;
        bus.LoadAddr = a;
        bus.LoadData = d;
        tick();
        bus.LoadEn   = 1'b0;
    endtask

    task automatic start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic wait_run(output int cyc);
        cyc = 0;
        while (bus.Run !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (bus.Halted !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
    endtask

    task automatic done_after(input int k);
        repeat (k) tick();
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
    endtask

    initial begin
        bus.LoadEn = 0; bus.LoadAddr = 0; bus.LoadData = 0;
        bus.Start = 0; bus.StepMode = 0; bus.Step = 0; bus.Done = 0;

        // Reset state
        repeat (2) tick();
        check("rst_instr",  32'(bus.Instr), 32'h0);
        check("rst_run",    32'(bus.Run), 32'h0);
        check("rst_pc",     32'(bus.Pc), 32'h0);
        check("rst_busy",   32'(bus.Busy), 32'h0);
        check("rst_halted", 32'(bus.Halted), 32'h0);
        check("rst_fault",  32'(bus.Fault), 32'h0);
        Reset = 1'b1;
        tick();

        // Free-run three-word program
        load(4'd0, 16'h5105);
        load(4'd1, 16'h6211);
        load(4'd2, 16'h0000);
        snap = run_total;
        start();
        wait_run(n);
        check("fr_start_lat", 32'(n + 1), 32'd2);
        check("fr_instr0", 32'(bus.Instr), 32'h5105);
        done_after(4);
        wait_run(n);
        check("fr_done_lat", 32'(n + 1), 32'd2);
        check("fr_instr1", 32'(bus.Instr), 32'h6211);
        done_after(4);
        wait_halt(n);
        check("fr_halted", 32'(bus.Halted), 32'h1);
        check("fr_pc", 32'(bus.Pc), 32'd2);
        check("fr_runs", 32'(run_total - snap), 32'd2);

        // Single-step
        bus.StepMode = 1'b1;
        snap = run_total;
        start();
        wait_run(n);
        check("ss_instr0", 32'(bus.Instr), 32'h5105);
        done_after(4);
        check("ss_state_pause", 32'(dut.state_q), 32'(S_PAUSE));
        check("ss_busy", 32'(bus.Busy), 32'h1);
        repeat (5) tick();
        check("ss_no_run", 32'(run_total - snap), 32'd1);
        bus.Step = 1'b1;
        tick();
        bus.Step = 1'b0;
        wait_run(n);
        check("ss_step_lat", 32'(n + 1), 32'd2);
        check("ss_instr1", 32'(bus.Instr), 32'h6211);
        bus.StepMode = 1'b0;
        done_after(4);
        wait_halt(n);
        check("ss_pc", 32'(bus.Pc), 32'd2);

        // Reset mid-WAIT
        load(4'd3, 16'h1234);
        load(4'd0, 16'h4100);
        start();
        wait_run(n);
        tick();
        tick();
        check("mr_in_wait", 32'(dut.state_q), 32'(S_WAIT));
        #2 Reset = 1'b0;
        #1;
        check("mr_state", 32'(dut.state_q), 32'(S_IDLE));
        check("mr_busy", 32'(bus.Busy), 32'h0);
        check("mr_run", 32'(bus.Run), 32'h0);
        check("mr_instr", 32'(bus.Instr), 32'h0);
        check("mr_mem3", 32'(dut.u_mem.mem_q[3]), 32'h0);
        tick();
        Reset = 1'b1;
        snap = run_total;
        repeat (10) tick();
        check("mr_no_run", 32'(run_total - snap), 32'd0);
        check("mr_idle_busy", 32'(bus.Busy), 32'h0);

        // Timeout fault and restart
        load(4'd0, 16'h4100);
        load(4'd1, 16'h0000);
        start();
        wait_run(n);
        repeat (15) tick();
        check("to_not_yet", 32'(bus.Fault), 32'h0);
        tick();
        check("to_fault", 32'(bus.Fault), 32'h1);
        check("to_pc", 32'(bus.Pc), 32'd0);
        check("to_busy", 32'(bus.Busy), 32'h0);
        start();
        check("to_cleared", 32'(bus.Fault), 32'h0);
        wait_run(n);
        check("to_reissue_lat", 32'(n + 1), 32'd2);
        check("to_reissue", 32'(bus.Instr), 32'h4100);
        done_after(4);
        wait_halt(n);
        check("to_halt_pc", 32'(bus.Pc), 32'd1);

        // Full memory, no wrap
        for (int i = 0; i < 16; i++) load(4'(i), 16'(32'h4000 + i));
        snap = run_total;
        start();
        for (int i = 0; i < 16; i++) begin
            wait_run(n);
            check($sformatf("fm_instr%0d", i), 32'(bus.Instr), 32'h4000 + 32'(i));
            done_after(4);
        end
        check("fm_halted", 32'(bus.Halted), 32'h1);
        check("fm_pc", 32'(bus.Pc), 32'd15);
        check("fm_runs", 32'(run_total - snap), 32'd16);
        repeat (5) tick();
        check("fm_nowrap_pc", 32'(bus.Pc), 32'd15);
        check("fm_nowrap_runs", 32'(run_total - snap), 32'd16);

        // Done held high across ISSUE; LoadEn ignored in WAIT
        load(4'd0, 16'h4100);
        load(4'd1, 16'h0000);
        bus.Done = 1'b1;
        start();
        wait_run(n);
        repeat (5) tick();
        check("dh_still_wait", 32'(dut.state_q), 32'(S_WAIT));
        check("dh_pc", 32'(bus.Pc), 32'd0);
        load(4'd0, 16'hFFFF);
        bus.Done = 1'b0;
        tick();
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        wait_halt(n);
        check("dh_halt_pc", 32'(bus.Pc), 32'd1);
        start();
        wait_run(n);
        check("dh_mem_kept", 32'(bus.Instr), 32'h4100);
        done_after(4);
        wait_halt(n);
        check("dh_final_halt", 32'(bus.Halted), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
